// File: rtl/ktms_db_pkg.sv
// Shared doorbell helpers: write-data INC offset and saturating counter update.
// Used by ktms_mmwr_doorbell (optional KTMS_MMWR_DB_OVFL_EN overflow reporting).
package ktms_db_pkg;

  localparam int unsigned DB_DATA_W = 64;
  // Wide enough for any supported counter (cnt_width <= 32) plus carry and guard bits.
  localparam int unsigned DB_SUM_W  = 34;

  // INC occupies the low-order cnt_w bits of the 64-bit MSB-first write word.
  function automatic int unsigned db_inc_offset(input int unsigned cnt_w);
    return DB_DATA_W - cnt_w;
  endfunction

  function automatic logic [DB_SUM_W-1:0] db_sat_add(
    input logic [DB_SUM_W-1:0] cnt,
    input logic [DB_SUM_W-1:0] inc,
    input logic                dec,
    input int unsigned         cnt_w
  );
    logic [DB_SUM_W-1:0] sum;
    logic [DB_SUM_W-1:0] maxc;
    sum  = cnt + inc - DB_SUM_W'(dec);
    maxc = (DB_SUM_W'(1) << cnt_w) - DB_SUM_W'(1);
    return (sum > maxc) ? maxc : sum;
  endfunction

endpackage

// File: rtl/ktms_db_rrarb.sv
// Round-robin search: first requesting index starting at (last_i + 1) mod NC.
module ktms_db_rrarb #(
  parameter int NC = 2,
  parameter int IW = 1
) (
  input  logic [NC-1:0] req_i,
  input  logic [IW-1:0] last_i,
  output logic          gnt_v_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW-1:0] base;
  logic [NC-1:0] rot;
  logic [IW-1:0] off;

  // NC is a power of two, so IW-bit wraparound gives the modulo for free.
  assign base = last_i + IW'(1);

  for (genvar gi = 0; gi < NC; gi++) begin : g_rot
    logic [IW-1:0] idx;
    assign idx     = base + IW'(gi);
    assign rot[gi] = req_i[idx];
  end

  always_comb begin
    off = '0;
    for (int i = NC - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
  end

  assign gnt_v_o   = |req_i;
  assign gnt_idx_o = base + off;

endmodule

// File: rtl/ktms_mmwr_doorbell.sv
// MMIO-write doorbell: per-context pending counters drained one grant per cycle, round-robin.
// Define KTMS_MMWR_DB_OVFL_EN to add the o_ovfl counter-overflow pulse output.
module ktms_mmwr_doorbell
  import ktms_db_pkg::*;
#(
  parameter int ctxt_width = 1,
  parameter int cnt_width  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr_v,
  output logic                  i_wr_r,
  input  logic [ctxt_width-1:0] i_wr_addr,
  input  logic [0:63]           i_wr_d,
  output logic                  o_v,
  input  logic                  o_r,
  output logic [ctxt_width-1:0] o_ctxt
`ifdef KTMS_MMWR_DB_OVFL_EN
  ,
  output logic                  o_ovfl
`endif
);

  localparam int NC = 1 << ctxt_width;
  localparam int unsigned INC_OFF = db_inc_offset(cnt_width);

  logic [cnt_width-1:0]  cnt_q [NC];
  logic [cnt_width-1:0]  cnt_d [NC];
  logic [ctxt_width-1:0] last_q;
  logic                  o_v_q;
  logic [ctxt_width-1:0] o_ctxt_q;

  logic                  wr_acc;
  logic                  xfer;
  logic                  load;
  logic [cnt_width-1:0]  inc;
  logic [NC-1:0]         req;
  logic                  gnt_v;
  logic [ctxt_width-1:0] gnt_idx;
  logic                  unused_wr_d;

  assign i_wr_r      = ~reset;
  assign wr_acc      = i_wr_v & i_wr_r;
  assign xfer        = o_v_q & o_r;
  assign load        = ~o_v_q | o_r;
  assign inc         = i_wr_d[INC_OFF +: cnt_width];
  assign unused_wr_d = ^i_wr_d;

`ifdef KTMS_MMWR_DB_OVFL_EN
  logic [NC-1:0] ovf;
  logic          o_ovfl_q;
`endif

  for (genvar gi = 0; gi < NC; gi++) begin : g_ctx
    logic wr_hit;
    logic rd_hit;
    assign wr_hit = wr_acc & (i_wr_addr == ctxt_width'(gi));
    assign rd_hit = xfer & (o_ctxt_q == ctxt_width'(gi));
    // A write and a transfer on the same context fold into one update.
    assign cnt_d[gi] = cnt_width'(db_sat_add(DB_SUM_W'(cnt_q[gi]),
                                             wr_hit ? DB_SUM_W'(inc) : '0,
                                             rd_hit, cnt_width));
    assign req[gi] = |cnt_d[gi];
`ifdef KTMS_MMWR_DB_OVFL_EN
    logic [cnt_width+1:0] sum;
    assign sum = {2'b00, cnt_q[gi]} + (wr_hit ? {2'b00, inc} : '0)
               - {{(cnt_width+1){1'b0}}, rd_hit};
    assign ovf[gi] = sum > {2'b00, {cnt_width{1'b1}}};
`endif
  end

  // Arbitrate on post-update counts so a context draining to zero is never granted.
  ktms_db_rrarb #(
    .NC (NC),
    .IW (ctxt_width)
  ) u_rrarb (
    .req_i     (req),
    .last_i    (last_q),
    .gnt_v_o   (gnt_v),
    .gnt_idx_o (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NC; c++) cnt_q[c] <= '0;
      last_q   <= ctxt_width'(NC - 1);
      o_v_q    <= 1'b0;
      o_ctxt_q <= '0;
    end else begin
      for (int c = 0; c < NC; c++) cnt_q[c] <= cnt_d[c];
      if (load) begin
        o_v_q <= gnt_v;
        if (gnt_v) begin
          o_ctxt_q <= gnt_idx;
          last_q   <= gnt_idx;
        end
      end
    end
  end

`ifdef KTMS_MMWR_DB_OVFL_EN
  always_ff @(posedge clk) begin
    if (reset) o_ovfl_q <= 1'b0;
    else       o_ovfl_q <= |ovf;
  end
  assign o_ovfl = o_ovfl_q;
`endif

  assign o_v    = o_v_q;
  assign o_ctxt = o_ctxt_q;

endmodule

// File: tb/tb_ktms_mmwr_doorbell.sv
// Directed self-checking bench for ktms_mmwr_doorbell (default parameters, NC=2, 8-bit counts).
module tb_ktms_mmwr_doorbell;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_wr_v;
  logic        i_wr_r;
  logic [0:0]  i_wr_addr;
  logic [0:63] i_wr_d;
  logic        o_v;
  logic        o_r;
  logic [0:0]  o_ctxt;
`ifdef KTMS_MMWR_DB_OVFL_EN
  logic        o_ovfl;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  ktms_mmwr_doorbell #(
    .ctxt_width (1),
    .cnt_width  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_wr_v    (i_wr_v),
    .i_wr_r    (i_wr_r),
    .i_wr_addr (i_wr_addr),
    .i_wr_d    (i_wr_d),
    .o_v       (o_v),
    .o_r       (o_r),
    .o_ctxt    (o_ctxt)
`ifdef KTMS_MMWR_DB_OVFL_EN
    ,
    .o_ovfl    (o_ovfl)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Upper 56 bits carry junk; only the low 8 bits form INC.
  task automatic wr(input int c, input int inc);
    i_wr_v    = 1'b1;
    i_wr_addr = c[0:0];
    i_wr_d    = {56'h5A5A5A5A5A5A5A, 8'(inc)};
  endtask

  task automatic idle();
    i_wr_v = 1'b0;
    i_wr_d = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    o_r = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input int budget, output int n);
    n   = 0;
    o_r = 1'b1;
    for (int k = 0; k < budget && o_v; k++) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    o_r = 1'b0;
    i_wr_addr = '0;
    tick();
    tick();
    n_chk++; if (o_v !== 1'b0) begin n_fail++; $display("FAIL reset_o_v: got %b want 0", o_v); end
    n_chk++; if (o_ctxt !== 1'b0) begin n_fail++; $display("FAIL reset_o_ctxt: got %0d want 0", o_ctxt); end
    n_chk++; if (i_wr_r !== 1'b0) begin n_fail++; $display("FAIL reset_wr_r: got %b want 0", i_wr_r); end
`ifdef KTMS_MMWR_DB_OVFL_EN
    n_chk++; if (o_ovfl !== 1'b0) begin n_fail++; $display("FAIL reset_ovfl: got %b want 0", o_ovfl); end
`endif
    reset = 1'b0;
    tick();
    n_chk++; if (i_wr_r !== 1'b1) begin n_fail++; $display("FAIL post_reset_wr_r: got %b want 1", i_wr_r); end
    n_chk++; if (o_v !== 1'b0) begin n_fail++; $display("FAIL post_reset_o_v: got %b want 0", o_v); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    o_r = 1'b1;
    wr(1, 3);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (o_v !== 1'b1) begin n_fail++; $display("FAIL single_v%0d: got %b want 1", k, o_v); end
      n_chk++; if (o_ctxt !== 1'b1) begin n_fail++; $display("FAIL single_ctxt%0d: got %0d want 1", k, o_ctxt); end
      tick();
    end
    n_chk++; if (o_v !== 1'b0) begin n_fail++; $display("FAIL single_end_v: got %b want 0", o_v); end
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    logic [0:0] exp_seq [4];
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    o_r = 1'b1;
    wr(0, 2);
    tick();
    wr(1, 2);
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (o_v !== 1'b1 || o_ctxt !== exp_seq[k]) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got v=%b ctxt=%0d want v=1 ctxt=%0d", k, o_v, o_ctxt, exp_seq[k]);
      end
      tick();
      idle();
    end
    n_chk++; if (o_v !== 1'b0) begin n_fail++; $display("FAIL rr_end_v: got %b want 0", o_v); end
    $display("test_round_robin done");
  endtask

  task automatic test_stall();
    int n;
    do_reset();
    o_r = 1'b0;
    wr(0, 2);
    tick();
    wr(1, 1);
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if (o_v !== 1'b1 || o_ctxt !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got v=%b ctxt=%0d want v=1 ctxt=0", k, o_v, o_ctxt);
      end
      tick();
      idle();
    end
    drain(20, n);
    n_chk++; if (n != 3) begin n_fail++; $display("FAIL stall_drain: got %0d grants want 3", n); end
    $display("test_stall done");
  endtask

  task automatic test_combined();
    do_reset();
    o_r = 1'b0;
    wr(0, 1);
    tick();
    idle();
    n_chk++; if (o_v !== 1'b1 || o_ctxt !== 1'b0) begin n_fail++; $display("FAIL comb_pre: got v=%b ctxt=%0d want v=1 ctxt=0", o_v, o_ctxt); end
    o_r = 1'b1;
    wr(0, 1);
    tick();
    idle();
    n_chk++; if (o_v !== 1'b1 || o_ctxt !== 1'b0) begin n_fail++; $display("FAIL comb_regrant: got v=%b ctxt=%0d want v=1 ctxt=0", o_v, o_ctxt); end
    tick();
    n_chk++; if (o_v !== 1'b0) begin n_fail++; $display("FAIL comb_end_v: got %b want 0", o_v); end
    $display("test_combined done");
  endtask

  task automatic test_saturate();
    int n;
    do_reset();
    o_r = 1'b0;
    wr(0, 250);
    tick();
`ifdef KTMS_MMWR_DB_OVFL_EN
    n_chk++; if (o_ovfl !== 1'b0) begin n_fail++; $display("FAIL sat_no_ovfl: got %b want 0", o_ovfl); end
`endif
    wr(0, 10);
    tick();
    idle();
`ifdef KTMS_MMWR_DB_OVFL_EN
    n_chk++; if (o_ovfl !== 1'b1) begin n_fail++; $display("FAIL sat_ovfl_pulse: got %b want 1", o_ovfl); end
`endif
    tick();
`ifdef KTMS_MMWR_DB_OVFL_EN
    n_chk++; if (o_ovfl !== 1'b0) begin n_fail++; $display("FAIL sat_ovfl_clear: got %b want 0", o_ovfl); end
`endif
    drain(300, n);
    n_chk++; if (n != 255) begin n_fail++; $display("FAIL sat_drain: got %0d grants want 255", n); end
    $display("test_saturate done");
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    o_r = 1'b0;
    wr(1, 4);
    tick();
    idle();
    n_chk++; if (o_v !== 1'b1 || o_ctxt !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got v=%b ctxt=%0d want v=1 ctxt=1", o_v, o_ctxt); end
    // Transfer and write presented during reset must both be dropped.
    reset = 1'b1;
    o_r   = 1'b1;
    wr(0, 5);
    #1;
    n_chk++; if (i_wr_r !== 1'b0) begin n_fail++; $display("FAIL mid_wr_r: got %b want 0", i_wr_r); end
    tick();
    reset = 1'b0;
    idle();
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (o_v !== 1'b0) begin n_fail++; $display("FAIL mid_idle%0d: got %b want 0", k, o_v); end
      tick();
    end
    wr(0, 1);
    tick();
    idle();
    n_chk++; if (o_v !== 1'b1 || o_ctxt !== 1'b0) begin n_fail++; $display("FAIL mid_new: got v=%b ctxt=%0d want v=1 ctxt=0", o_v, o_ctxt); end
    tick();
    n_chk++; if (o_v !== 1'b0) begin n_fail++; $display("FAIL mid_end_v: got %b want 0", o_v); end
    $display("test_reset_mid_burst done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_combined();
    test_saturate();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ktms_mmwr_doorbell.md
KTMS_MMWR_DOORBELL -- requirements
Module: ktms_mmwr_doorbell

Interface
REQ-001 SHALL have parameter ctxt_width, default 1, meaning local context index width (matches upstream decoder lcladdr_width); number of contexts NC = 2^ctxt_width.
REQ-002 SHALL have parameter cnt_width, default 8, meaning per-context pending-doorbell counter width; MAXC = 2^cnt_width-1.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_wr_v, input, 1, decoded MMIO write valid from the upstream write decoder.
REQ-006 SHALL have port i_wr_r, output, 1, ready back to the upstream write decoder.
REQ-007 SHALL have port i_wr_addr, input, ctxt_width, target context index.
REQ-008 SHALL have port i_wr_d, input, 64 (bit 0 = MSB), write data; increment INC = i_wr_d[64-cnt_width:63].
REQ-009 SHALL have port o_v, output, 1, doorbell grant valid to the downstream consumer.
REQ-010 SHALL have port o_r, input, 1, downstream ready.
REQ-011 SHALL have port o_ctxt, output, ctxt_width, granted context index.
REQ-012 SHALL have port o_ovfl, output, 1, overflow error pulse (present only per REQ-030).

Function
REQ-013 SHALL hold one cnt_width counter CNT[c] per context.
REQ-014 SHALL drive i_wr_r = 1 in every cycle except a cycle where reset is sampled high.
REQ-015 SHALL accept a write when i_wr_v & i_wr_r, and treat an accepted write with INC = 0 as a no-op.
REQ-016 SHALL fire a transfer when o_v & o_r, decrementing CNT[o_ctxt] by 1.
REQ-017 SHALL compute the next count as CNT + INC (if the write targets c) - 1 (if the transfer targets c), saturating at MAXC, with the sum evaluated in cnt_width+2 bits.
REQ-018 SHALL treat a simultaneous write and transfer to the same context in one cycle as a single combined update per REQ-017; no event is lost.
REQ-019 SHALL load the output register (o_v, o_ctxt) only in a cycle where ~o_v | o_r.
REQ-020 SHALL derive the load from next-state counts: o_v' = any(next CNT != 0), and o_ctxt' = the first context with nonzero next count, searching round-robin from (LAST+1) mod NC.
REQ-021 SHALL set LAST to the granted context on each load with o_v' = 1.
REQ-022 SHALL hold o_v and o_ctxt stable while o_v & ~o_r.
REQ-023 SHALL give latency: write accepted in cycle N with o_v low makes o_v = 1 in cycle N+1.
REQ-024 SHALL never grant a context whose count would reach zero after the current transfer (REQ-020 uses post-decrement counts).
REQ-025 SHALL allow back-to-back grants (one per cycle) while o_r = 1 and work is pending.

Reset
REQ-026 SHALL, while reset is high, clear all CNT[c] to 0, LAST to NC-1, o_v to 0, o_ctxt to 0, and o_ovfl to 0.
REQ-027 SHALL discard any write or transfer presented in a reset cycle.
REQ-028 SHALL resume normal operation on the first cycle after reset deasserts, including when reset occurs mid-burst.

Configuration
REQ-029 SHALL use macro KTMS_MMWR_DB_OVFL_EN to select overflow reporting.
REQ-030 SHALL, when KTMS_MMWR_DB_OVFL_EN is defined, provide o_ovfl as a registered 1-cycle pulse in the cycle after a REQ-017 sum exceeds MAXC.
REQ-031 SHALL, when KTMS_MMWR_DB_OVFL_EN is undefined, omit o_ovfl; saturation still applies and the overflow is not reported.

Structure
REQ-032 SHALL place the INC-extraction offset and the counter saturating-add function in shared package ktms_db_pkg.
REQ-033 SHALL implement the round-robin search as sub-module ktms_db_rrarb (inputs: request mask, LAST; outputs: grant valid, grant index).

Verification
REQ-034 SHALL cover: reset, then write ctxt 1 with INC=3 and o_r=1 -> o_v the next cycle, o_ctxt=1 for exactly 3 consecutive cycles, then o_v=0.
REQ-035 SHALL cover: NC=2, writes INC=2 to ctxt 0 and ctxt 1 in consecutive cycles, o_r=1 -> o_ctxt sequence 0,1,0,1.
REQ-036 SHALL cover: o_r=0 with a pending grant for 5 cycles -> o_v and o_ctxt constant; counts unchanged apart from new writes.
REQ-037 SHALL cover: CNT[0]=1 with o_v high for ctxt 0, write INC=1 to ctxt 0 in the fire cycle -> CNT[0]=1 afterward and o_v high again for ctxt 0 next cycle.
REQ-038 SHALL cover: cnt_width=8, CNT[0]=250, write INC=10 -> CNT[0]=255; o_ovfl pulses once with the macro, no o_ovfl port without it.
REQ-039 SHALL cover: reset asserted mid-burst with CNT[1]=4 -> o_v=0 and all counts 0 the next cycle; no grant until a new write.
